regfile_op_sequencer: RTL and testbench

- Multi-cycle initiator for the 2-read/1-write register bank.
- Accepts one command (rs1, rs2, rd, op) per valid/ready handshake and drives the bank's read pointers.
- Captures both operands, computes an ALU result, then drives the bank's write port for exactly one cycle.
- Sits between the instruction-issue logic and the register bank; it is the only agent that drives the bank's pointer and write ports.

---
 rtl/regfile_op_sequencer.sv | 120 ++++++++++++
 tb/tb_regfile_op_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle register-bank initiator: accepts (rs1, rs2, rd, op), reads both
// operands from the bank, computes an ALU result and writes it back once.
module regfile_op_sequencer #(
   parameter int N    = 32,
   parameter int Bits = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [$clog2(N)-1:0]   cmd_rs1,
   input  logic [$clog2(N)-1:0]   cmd_rs2,
   input  logic [$clog2(N)-1:0]   cmd_rd,
   input  logic [2:0]             cmd_op,
   output logic [$clog2(N)-1:0]   ptr_rd_1,
   output logic [$clog2(N)-1:0]   ptr_rd_2,
   input  logic [Bits-1:0]        data_rd_1,
   input  logic [Bits-1:0]        data_rd_2,
   output logic [$clog2(N)-1:0]   ptr_wr,
   output logic [Bits-1:0]        data_wr,
   output logic                   wr_en,
   output logic                   done,
   output logic [Bits-1:0]        result
);

   localparam int PW = $clog2(N);
   localparam int SW = $clog2(Bits);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   ptr_rd_1_reg, ptr_rd_2_reg, rd_reg, ptr_wr_reg;
   logic [2:0]      op_reg;
   logic [Bits-1:0] a_reg, b_reg, data_wr_reg, result_reg;
   logic [Bits-1:0] alu_out;
   logic            accept;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Handshake and bank strobes are gated by rst so nothing escapes during reset.
   always_comb begin
      state_next = state_reg;
      cmd_ready  = 1'b0;
      wr_en      = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            cmd_ready = !rst;
            if (cmd_valid) state_next = READ;
         end
         READ:  state_next = EXEC;
         EXEC:  state_next = WRITE;
         WRITE: begin
            done       = !rst;
            wr_en      = !rst && (ptr_wr_reg != '0);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = cmd_valid && cmd_ready;

   always_comb begin
      alu_out = '0;
      case (op_reg)
         3'b000: alu_out = a_reg + b_reg;
         3'b001: alu_out = a_reg - b_reg;
         3'b010: alu_out = a_reg & b_reg;
         3'b011: alu_out = a_reg | b_reg;
         3'b100: alu_out = a_reg ^ b_reg;
         3'b101: alu_out = a_reg << b_reg[SW-1:0];
         3'b110: alu_out = a_reg >> b_reg[SW-1:0];
         3'b111: alu_out = {{(Bits-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
         default: alu_out = '0;
      endcase
   end

   // Operands are sampled at the end of READ, so a write from the previous
   // command (landed at the end of its WRITE) is always visible here.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_rd_1_reg <= '0;
         ptr_rd_2_reg <= '0;
         rd_reg       <= '0;
         op_reg       <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         ptr_wr_reg   <= '0;
         data_wr_reg  <= '0;
         result_reg   <= '0;
      end else begin
         if (accept) begin
            ptr_rd_1_reg <= cmd_rs1;
            ptr_rd_2_reg <= cmd_rs2;
            rd_reg       <= cmd_rd;
            op_reg       <= cmd_op;
         end
         if (state_reg == READ) begin
            a_reg <= data_rd_1;
            b_reg <= data_rd_2;
         end
         if (state_reg == EXEC) begin
            data_wr_reg <= alu_out;
            result_reg  <= alu_out;
            ptr_wr_reg  <= rd_reg;
         end
      end
   end

   assign ptr_rd_1 = ptr_rd_1_reg;
   assign ptr_rd_2 = ptr_rd_2_reg;
   assign ptr_wr   = ptr_wr_reg;
   assign data_wr  = data_wr_reg;
   assign result   = result_reg;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer: behavioural bank model, expected
// completions queued at issue time and checked by an independent monitor.
module tb_regfile_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
   logic [2:0]  cmd_op;
   logic [4:0]  ptr_rd_1, ptr_rd_2, ptr_wr;
   logic [63:0] data_rd_1, data_rd_2, data_wr, result;
   logic        wr_en, done;

   logic [63:0] bank [0:31];
   logic        clr, pl_en;
   logic [4:0]  pl_addr;
   logic [63:0] pl_data;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic        we;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                          XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, SLT = 3'd7;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   always #5 clk = ~clk;

   regfile_op_sequencer #(.N(32), .Bits(64)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_op(cmd_op),
      .ptr_rd_1(ptr_rd_1), .ptr_rd_2(ptr_rd_2), .data_rd_1(data_rd_1),
      .data_rd_2(data_rd_2), .ptr_wr(ptr_wr), .data_wr(data_wr),
      .wr_en(wr_en), .done(done), .result(result)
   );

   // Bank model: combinational read, write on the clock edge.
   assign data_rd_1 = bank[ptr_rd_1];
   assign data_rd_2 = bank[ptr_rd_2];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (clr) begin
         for (int i = 0; i < 32; i++) bank[i] <= '0;
      end else if (pl_en) begin
         bank[pl_addr] <= pl_data;
      end else if (wr_en) begin
         bank[ptr_wr] <= data_wr;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (wr_en && !done) begin
         tests++; fails++;
         $display("FAIL stray_wr_en: got wr_en=1 with done=0 (cycle %0d)", cyc);
      end
      if (done) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            $display("[TB] done cyc=%0d rd=%0d we=%0b data=0x%0h", cyc, ptr_wr, wr_en, data_wr);
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("result", result, e.data);
            chk("data_wr", data_wr, e.data);
            chk("wr_en", 64'(wr_en), 64'(e.we));
            chk("ptr_wr", 64'(ptr_wr), 64'(e.rd));
         end
      end
   end

   task automatic preload(input logic [4:0] a, input logic [63:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [2:0] op, input logic [63:0] exp, input bit push,
                        output int acc);
      int w;
      exp_t e;
      @(negedge clk);
      cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_op = op; cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      acc = cyc;
      if (!cmd_ready) begin
         tests++; fails++;
         $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 20 cycles");
      end else if (push) begin
         e.rd = rd; e.data = exp; e.we = (rd != 0); e.cyc = cyc + 3;
         sb.push_back(e);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         tests++; fails++;
         $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      end
      @(negedge clk);
   endtask

   initial begin
      int a0, a1, last;
      int n_acc;
      rst = 1'b1; clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      cmd_valid = 1'b0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_op = '0;
      repeat (3) @(negedge clk);
      chk("ready_in_reset", 64'(cmd_ready), 64'd0);
      chk("wr_en_in_reset", 64'(wr_en), 64'd0);
      rst = 1'b0; clr = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ptr_rd_1", 64'(ptr_rd_1), 64'd0);
      chk("rst_ptr_rd_2", 64'(ptr_rd_2), 64'd0);
      chk("rst_ptr_wr", 64'(ptr_wr), 64'd0);
      chk("rst_data_wr", data_wr, 64'd0);
      chk("rst_result", result, 64'd0);

      // Basic ADD
      preload(1, 64'd5); preload(2, 64'd7);
      issue(1, 2, 3, ADD, 64'd12, 1, a0);
      wait_done();
      chk("x3_after_add", bank[3], 64'd12);
      repeat (3) @(negedge clk);
      chk("result_held", result, 64'd12);

      // Wrap and SUB
      preload(1, ONES); preload(2, 64'd1);
      issue(1, 2, 4, ADD, 64'd0, 1, a0); wait_done();
      preload(1, 64'd0);
      issue(1, 2, 4, SUB, ONES, 1, a0); wait_done();
      chk("x4_after_sub", bank[4], ONES);

      // Logic ops
      preload(1, 64'hF0F0); preload(2, 64'hFF00);
      issue(1, 2, 5, AND_, 64'hF000, 1, a0); wait_done();
      issue(1, 2, 5, OR_,  64'hFFF0, 1, a0); wait_done();
      issue(1, 2, 5, XOR_, 64'h0FF0, 1, a0); wait_done();

      // Shifts and SLT
      preload(1, 64'd1); preload(2, 64'h43);
      issue(1, 2, 5, SLL, 64'd8, 1, a0); wait_done();
      preload(1, ONES); preload(2, 64'd0);
      issue(1, 2, 5, SLT, 64'd1, 1, a0); wait_done();
      issue(2, 1, 5, SLT, 64'd0, 1, a0); wait_done();
      preload(2, 64'd63);
      issue(1, 2, 5, SRL, 64'd1, 1, a0); wait_done();
      chk("x5_after_srl", bank[5], 64'd1);

      // rd=0 never written
      preload(1, 64'd3); preload(2, 64'd4);
      issue(1, 2, 0, ADD, 64'd7, 1, a0); wait_done();
      chk("x0_stays_zero", bank[0], 64'd0);

      // Back-to-back with RAW dependency
      issue(1, 2, 5, ADD, 64'd7, 1, a0);
      issue(5, 5, 6, ADD, 64'd14, 1, a1);
      chk("b2b_accept_gap", 64'(a1 - a0), 64'd4);
      wait_done();
      chk("x6_raw", bank[6], 64'd14);

      // Continuous cmd_valid: one accept per 4 cycles
      preload(1, 64'd5); preload(2, 64'd7);
      n_acc = 0; last = 0;
      for (int i = 0; i < 12; i++) begin
         exp_t e;
         @(negedge clk);
         cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_rd = 5'd7; cmd_op = ADD; cmd_valid = 1'b1;
         if (cmd_ready) begin
            if (n_acc > 0) chk("busy_gap", 64'(cyc - last), 64'd4);
            last = cyc;
            n_acc++;
            e.rd = 5'd7; e.data = 64'd12; e.we = 1'b1; e.cyc = cyc + 3;
            sb.push_back(e);
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("busy_accepts", 64'(n_acc), 64'd3);
      wait_done();
      chk("x7_busy", bank[7], 64'd12);

      // Reset during EXEC drops the write
      preload(9, 64'h55);
      issue(1, 2, 9, ADD, 64'd0, 0, a0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
      chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 64'(cmd_ready), 64'd1);
      chk("post_rst_done", 64'(done), 64'd0);
      chk("x9_dropped", bank[9], 64'h55);
      issue(1, 2, 9, ADD, 64'd12, 1, a0); wait_done();
      chk("x9_after_rst", bank[9], 64'd12);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
